// File: rtl/conv_pkg.sv
// Shared types and default geometry for the convolution output writeback path.
package conv_pkg;

    typedef enum logic [1:0] {
        WB_IDLE,
        WB_RUN,
        WB_FLUSH,
        WB_DONE
    } wb_state_t;

    localparam int DEF_OUT_H  = 56;
    localparam int DEF_OUT_W  = 56;
    localparam int DEF_C_OUT  = 32;
    localparam int DEF_NUM_PE = 16;
    localparam int DEF_ADDR_W = 20;

    localparam int WORDS_PER_PIX = DEF_NUM_PE / 4;

    // Byte k of a capture sits at [127-8k -: 8], so channel 0 is the top byte.
    typedef logic [127:0] pix_bytes_t;

    function automatic logic [31:0] select_word(input pix_bytes_t bytes, input logic [1:0] w);
        logic [31:0] word;
        case (w)
            2'd0:    word = bytes[127:96];
            2'd1:    word = bytes[95:64];
            2'd2:    word = bytes[63:32];
            default: word = bytes[31:0];
        endcase
        return word;
    endfunction

endpackage

// File: rtl/ofm_pixel_buf.sv
// Two-entry FIFO holding captured pixel bytes together with their (pix, tile) position.
module ofm_pixel_buf
    import conv_pkg::*;
#(
    parameter int PIX_W  = 12,
    parameter int TILE_W = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  pix_bytes_t        push_bytes,
    input  logic [PIX_W-1:0]  push_pix,
    input  logic [TILE_W-1:0] push_tile,
    output pix_bytes_t        head_bytes,
    output logic [PIX_W-1:0]  head_pix,
    output logic [TILE_W-1:0] head_tile,
    output logic              full,
    output logic              empty,
    output logic [1:0]        count
);

    pix_bytes_t        bytes_mem [2];
    logic [PIX_W-1:0]  pix_mem   [2];
    logic [TILE_W-1:0] tile_mem  [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

    // When full, a push is still legal if the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    assign head_bytes = bytes_mem[rd_ptr];
    assign head_pix   = pix_mem[rd_ptr];
    assign head_tile  = tile_mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                bytes_mem[i] <= '0;
                pix_mem[i]   <= '0;
                tile_mem[i]  <= '0;
            end
        end else if (clear) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                bytes_mem[wr_ptr] <= push_bytes;
                pix_mem[wr_ptr]   <= push_pix;
                tile_mem[wr_ptr]  <= push_tile;
                wr_ptr            <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ofm_writeback.sv
// Captures 16 PE result bytes per pixel and writes them to OFM BRAM as 32-bit HWC words.
module ofm_writeback
    import conv_pkg::*;
#(
    parameter int OUT_H  = DEF_OUT_H,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int C_OUT  = DEF_C_OUT,
    parameter int NUM_PE = DEF_NUM_PE,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       valid,
    input  logic [7:0]        OFM_0,
    input  logic [7:0]        OFM_1,
    input  logic [7:0]        OFM_2,
    input  logic [7:0]        OFM_3,
    input  logic [7:0]        OFM_4,
    input  logic [7:0]        OFM_5,
    input  logic [7:0]        OFM_6,
    input  logic [7:0]        OFM_7,
    input  logic [7:0]        OFM_8,
    input  logic [7:0]        OFM_9,
    input  logic [7:0]        OFM_10,
    input  logic [7:0]        OFM_11,
    input  logic [7:0]        OFM_12,
    input  logic [7:0]        OFM_13,
    input  logic [7:0]        OFM_14,
    input  logic [7:0]        OFM_15,
    output logic              ofm_wr_en,
    output logic [ADDR_W-1:0] ofm_addr,
    output logic [31:0]       ofm_data,
    output logic              busy,
    output logic              done,
    output logic              err_partial,
    output logic              err_overflow
);

    localparam int NUM_PIX = OUT_H * OUT_W;
    localparam int TILES   = C_OUT / NUM_PE;
    localparam int PIX_W   = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
    localparam int TILE_W  = (TILES > 1) ? $clog2(TILES) : 1;

    localparam logic [ADDR_W-1:0] PIX_STRIDE  = ADDR_W'(C_OUT / 4);
    localparam logic [ADDR_W-1:0] TILE_STRIDE = ADDR_W'(NUM_PE / 4);

    wb_state_t         state;
    logic [PIX_W-1:0]  pix_cnt;
    logic [TILE_W-1:0] tile_cnt;
    logic [1:0]        word_idx;

    pix_bytes_t        capture_bytes;
    pix_bytes_t        head_bytes;
    logic [PIX_W-1:0]  head_pix;
    logic [TILE_W-1:0] head_tile;
    logic              buf_full;
    logic              buf_empty;
    logic [1:0]        buf_count;

    logic              run_active;
    logic              capture_req;
    logic              partial;
    logic              pop;
    logic              push;
    logic              overflow;
    logic              last_pix;
    logic              last_tile;
    logic [ADDR_W-1:0] head_addr;
    logic [31:0]       head_word;

    assign capture_bytes = {OFM_0, OFM_1, OFM_2,  OFM_3,  OFM_4,  OFM_5,  OFM_6,  OFM_7,
                            OFM_8, OFM_9, OFM_10, OFM_11, OFM_12, OFM_13, OFM_14, OFM_15};

    // start outranks any valid pattern arriving in the same cycle.
    assign run_active  = (state == WB_RUN) && !start;
    assign capture_req = run_active && (valid == 16'hFFFF);
    assign partial     = run_active && (valid != 16'h0000) && (valid != 16'hFFFF);
    assign pop         = !buf_empty && (word_idx == 2'd3) && !start;
    assign push        = capture_req && (!buf_full || pop);
    assign overflow    = capture_req && buf_full && !pop;

    assign last_pix  = (pix_cnt == PIX_W'(NUM_PIX - 1));
    assign last_tile = (tile_cnt == TILE_W'(TILES - 1));

    assign head_addr = ADDR_W'(head_pix) * PIX_STRIDE
                     + ADDR_W'(head_tile) * TILE_STRIDE
                     + ADDR_W'(word_idx);
    assign head_word = select_word(head_bytes, word_idx);

    ofm_pixel_buf #(
        .PIX_W  (PIX_W),
        .TILE_W (TILE_W)
    ) u_buf (
        .clk        (clk),
        .reset      (reset),
        .clear      (start),
        .push       (push),
        .pop        (pop),
        .push_bytes (capture_bytes),
        .push_pix   (pix_cnt),
        .push_tile  (tile_cnt),
        .head_bytes (head_bytes),
        .head_pix   (head_pix),
        .head_tile  (head_tile),
        .full       (buf_full),
        .empty      (buf_empty),
        .count      (buf_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= WB_IDLE;
            pix_cnt      <= '0;
            tile_cnt     <= '0;
            word_idx     <= 2'd0;
            ofm_wr_en    <= 1'b0;
            ofm_addr     <= '0;
            ofm_data     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_partial  <= 1'b0;
            err_overflow <= 1'b0;
        end else if (start) begin
            state        <= WB_RUN;
            pix_cnt      <= '0;
            tile_cnt     <= '0;
            word_idx     <= 2'd0;
            ofm_wr_en    <= 1'b0;
            busy         <= 1'b1;
            done         <= 1'b0;
            err_partial  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            // The head entry streams one word per cycle while anything is buffered.
            ofm_wr_en <= !buf_empty;
            if (!buf_empty) begin
                ofm_addr <= head_addr;
                ofm_data <= head_word;
                word_idx <= word_idx + 2'd1;
            end

            if (partial) begin
                err_partial <= 1'b1;
            end
            if (overflow) begin
                err_overflow <= 1'b1;
            end

            if (push) begin
                if (last_pix) begin
                    pix_cnt  <= '0;
                    tile_cnt <= last_tile ? '0 : tile_cnt + TILE_W'(1);
                end else begin
                    pix_cnt <= pix_cnt + PIX_W'(1);
                end
            end

            case (state)
                WB_IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                end
                WB_RUN: begin
                    if (push && last_pix && last_tile) begin
                        state <= WB_FLUSH;
                    end
                end
                WB_FLUSH: begin
                    if (buf_count == 2'd0) begin
                        state <= WB_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                WB_DONE: begin
                    state <= WB_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= WB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ofm_writeback.sv
// Directed bench for ofm_writeback: a queue model predicts every BRAM write from pixel/tile order.
module tb_ofm_writeback;

    localparam int OUT_H  = 56;
    localparam int OUT_W  = 56;
    localparam int C_OUT  = 32;
    localparam int NUM_PE = 16;
    localparam int ADDR_W = 20;
    localparam int NUM_PIX = OUT_H * OUT_W;
    localparam int TILES   = C_OUT / NUM_PE;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [15:0]       valid;
    logic [7:0]        ofm [16];
    logic              ofm_wr_en;
    logic [ADDR_W-1:0] ofm_addr;
    logic [31:0]       ofm_data;
    logic              busy;
    logic              done;
    logic              err_partial;
    logic              err_overflow;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_addr_q [$];
    logic [31:0] exp_data_q [$];
    int          model_pix  = 0;
    int          model_tile = 0;
    bit          model_run  = 0;

    int          cycle = 0;
    int          write_count = 0;
    int          last_write_cycle = -10;
    int          done_count = 0;
    int          done_cycle = -1;
    logic        busy_at_done = 1'b1;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;
    bit          seen_addr4 = 0;
    logic [31:0] data_at4 = '0;
    int          wc;

    always #5 clk = ~clk;

    ofm_writeback #(
        .OUT_H  (OUT_H),
        .OUT_W  (OUT_W),
        .C_OUT  (C_OUT),
        .NUM_PE (NUM_PE),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .valid        (valid),
        .OFM_0        (ofm[0]),
        .OFM_1        (ofm[1]),
        .OFM_2        (ofm[2]),
        .OFM_3        (ofm[3]),
        .OFM_4        (ofm[4]),
        .OFM_5        (ofm[5]),
        .OFM_6        (ofm[6]),
        .OFM_7        (ofm[7]),
        .OFM_8        (ofm[8]),
        .OFM_9        (ofm[9]),
        .OFM_10       (ofm[10]),
        .OFM_11       (ofm[11]),
        .OFM_12       (ofm[12]),
        .OFM_13       (ofm[13]),
        .OFM_14       (ofm[14]),
        .OFM_15       (ofm[15]),
        .ofm_wr_en    (ofm_wr_en),
        .ofm_addr     (ofm_addr),
        .ofm_data     (ofm_data),
        .busy         (busy),
        .done         (done),
        .err_partial  (err_partial),
        .err_overflow (err_overflow)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [7:0] seed, input int w);
        logic [7:0] b [4];
        for (int k = 0; k < 4; k++) b[k] = seed ^ 8'(4 * w + k);
        return {b[0], b[1], b[2], b[3]};
    endfunction

    // HWC layout: a pixel owns C_OUT/4 consecutive words, each tile fills NUM_PE/4 of them.
    task automatic model_capture(input logic [7:0] seed);
        for (int w = 0; w < 4; w++) begin
            exp_addr_q.push_back(32'(model_pix * (C_OUT / 4) + model_tile * (NUM_PE / 4) + w));
            exp_data_q.push_back(model_word(seed, w));
        end
        model_pix++;
        if (model_pix == NUM_PIX) begin
            model_pix = 0;
            model_tile++;
            if (model_tile == TILES) begin
                model_tile = 0;
                model_run  = 0;
            end
        end
    endtask

    task automatic model_flush();
        exp_addr_q.delete();
        exp_data_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one cycle of inputs (sampled at the next rising edge) and updates the model.
    task automatic applyStimulus(input logic s, input logic [15:0] v, input logic [7:0] seed, input bit accept);
        start = s;
        valid = v;
        for (int k = 0; k < 16; k++) ofm[k] = seed ^ 8'(k);
        @(posedge clk);
        #1;
        start = 1'b0;
        valid = 16'h0000;
        if (s) begin
            model_flush();
            model_pix  = 0;
            model_tile = 0;
            model_run  = 1;
        end else if (v == 16'hFFFF && model_run && accept) begin
            model_capture(seed);
        end
    endtask

    always @(negedge clk) begin
        cycle++;
        if (!reset) begin
            if (ofm_wr_en) begin
                write_count++;
                last_write_cycle = cycle;
                last_wr_addr     = 32'(ofm_addr);
                last_wr_data     = ofm_data;
                if (ofm_addr == ADDR_W'(4)) begin
                    seen_addr4 = 1;
                    data_at4   = ofm_data;
                end
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_write: got addr %0h data %0h, required no write", ofm_addr, ofm_data);
                end else begin
                    checkOutput("wr_addr", 32'(ofm_addr), exp_addr_q.pop_front());
                    checkOutput("wr_data", ofm_data, exp_data_q.pop_front());
                end
            end
            if (done) begin
                done_count++;
                done_cycle   = cycle;
                busy_at_done = busy;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        valid = 16'h0000;
        for (int k = 0; k < 16; k++) ofm[k] = 8'h00;
        idle(2);
        checkOutput("rst_wr_en", 32'(ofm_wr_en), 32'd0);
        checkOutput("rst_addr", 32'(ofm_addr), 32'd0);
        checkOutput("rst_data", ofm_data, 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err_partial", 32'(err_partial), 32'd0);
        checkOutput("rst_err_overflow", 32'(err_overflow), 32'd0);
        reset = 1'b0;
        idle(1);

        $display("[TB] single capture");
        applyStimulus(1'b1, 16'h0000, 8'h00, 1);
        checkOutput("busy_after_start", 32'(busy), 32'd1);
        wc = write_count;
        applyStimulus(1'b0, 16'hFFFF, 8'h00, 1);
        checkOutput("no_write_at_capture_edge", 32'(ofm_wr_en), 32'd0);
        idle(1);
        checkOutput("word0_wr_en", 32'(ofm_wr_en), 32'd1);
        checkOutput("word0_addr", 32'(ofm_addr), 32'd0);
        checkOutput("word0_data", ofm_data, 32'h00010203);
        idle(3);
        checkOutput("word3_addr", 32'(ofm_addr), 32'd3);
        checkOutput("word3_data", ofm_data, 32'h0C0D0E0F);
        idle(3);
        checkOutput("single_idle_wr_en", 32'(ofm_wr_en), 32'd0);
        checkOutput("single_idle_busy", 32'(busy), 32'd1);
        checkOutput("single_idle_done", 32'(done), 32'd0);
        checkOutput("single_write_count", 32'(write_count - wc), 32'd4);
        checkOutput("single_drained", 32'(exp_addr_q.size()), 32'd0);

        $display("[TB] partial valid");
        applyStimulus(1'b1, 16'h0000, 8'h00, 1);
        wc = write_count;
        applyStimulus(1'b0, 16'h00FF, 8'h55, 1);
        idle(6);
        checkOutput("partial_flag", 32'(err_partial), 32'd1);
        checkOutput("partial_no_write", 32'(write_count - wc), 32'd0);
        applyStimulus(1'b0, 16'hFFFF, 8'h20, 1);
        idle(6);
        checkOutput("partial_next_writes", 32'(write_count - wc), 32'd4);
        checkOutput("partial_next_last_addr", last_wr_addr, 32'd3);
        checkOutput("partial_sticky", 32'(err_partial), 32'd1);
        checkOutput("partial_no_overflow", 32'(err_overflow), 32'd0);

        $display("[TB] overflow");
        applyStimulus(1'b1, 16'h0000, 8'h00, 1);
        checkOutput("start_clears_partial", 32'(err_partial), 32'd0);
        wc = write_count;
        applyStimulus(1'b0, 16'hFFFF, 8'h40, 1);
        applyStimulus(1'b0, 16'hFFFF, 8'h50, 1);
        applyStimulus(1'b0, 16'hFFFF, 8'h60, 0);
        checkOutput("overflow_flag", 32'(err_overflow), 32'd1);
        idle(10);
        checkOutput("overflow_writes", 32'(write_count - wc), 32'd8);
        checkOutput("overflow_second_last_addr", last_wr_addr, 32'd11);
        applyStimulus(1'b0, 16'hFFFF, 8'h70, 1);
        idle(6);
        checkOutput("after_overflow_addr", last_wr_addr, 32'd19);
        checkOutput("after_overflow_data", last_wr_data, 32'h7C7D7E7F);
        checkOutput("overflow_drained", 32'(exp_addr_q.size()), 32'd0);

        $display("[TB] restart mid-drain");
        applyStimulus(1'b1, 16'h0000, 8'h00, 1);
        checkOutput("start_clears_overflow", 32'(err_overflow), 32'd0);
        wc = write_count;
        applyStimulus(1'b0, 16'hFFFF, 8'h80, 1);
        idle(1);
        applyStimulus(1'b1, 16'h0000, 8'h00, 1);
        idle(6);
        checkOutput("restart_only_word0", 32'(write_count - wc), 32'd1);
        applyStimulus(1'b0, 16'hFFFF, 8'h90, 1);
        idle(1);
        checkOutput("restart_next_wr_en", 32'(ofm_wr_en), 32'd1);
        checkOutput("restart_next_addr", 32'(ofm_addr), 32'd0);
        idle(5);
        checkOutput("restart_drained", 32'(exp_addr_q.size()), 32'd0);

        $display("[TB] async reset mid-drain");
        applyStimulus(1'b0, 16'hFFFF, 8'hA0, 1);
        idle(1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_rst_wr_en", 32'(ofm_wr_en), 32'd0);
        checkOutput("async_rst_busy", 32'(busy), 32'd0);
        model_flush();
        model_run = 0;
        idle(1);
        reset = 1'b0;
        idle(2);
        wc = write_count;
        applyStimulus(1'b0, 16'hFFFF, 8'hB0, 1);
        idle(6);
        checkOutput("idle_ignores_valid", 32'(write_count - wc), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_err_partial", 32'(err_partial), 32'd0);

        $display("[TB] full layer");
        applyStimulus(1'b1, 16'h0000, 8'h00, 1);
        seen_addr4 = 0;
        done_count = 0;
        wc = write_count;
        for (int t = 0; t < TILES; t++) begin
            for (int p = 0; p < NUM_PIX; p++) begin
                applyStimulus(1'b0, 16'hFFFF, 8'(p), 1);
                idle(3);
            end
        end
        for (int i = 0; i < 40 && done_count == 0; i++) idle(1);
        idle(5);
        checkOutput("layer_done_pulses", 32'(done_count), 32'd1);
        checkOutput("layer_done_after_last_write", 32'(done_cycle), 32'(last_write_cycle + 1));
        checkOutput("layer_busy_at_done", 32'(busy_at_done), 32'd0);
        checkOutput("layer_write_count", 32'(write_count - wc), 32'd25088);
        checkOutput("layer_last_addr", last_wr_addr, 32'd25087);
        checkOutput("layer_last_data", last_wr_data, 32'h33323130);
        checkOutput("layer_tile1_pix0_seen", 32'(seen_addr4), 32'd1);
        checkOutput("layer_tile1_pix0_data", data_at4, 32'h00010203);
        checkOutput("layer_drained", 32'(exp_addr_q.size()), 32'd0);
        checkOutput("layer_busy_end", 32'(busy), 32'd0);
        checkOutput("layer_err_partial", 32'(err_partial), 32'd0);
        checkOutput("layer_err_overflow", 32'(err_overflow), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
